rggen_bit_field_multi_mode: RTL
===============================

# rggen_bit_field_multi_mode

Register bit field that generalises plain read/write storage to selectable software access modes and adds per-bit hardware set/clear, software write lock and a registered change pulse. It sits inside a register, driving its slice `[MSB:LSB]` of the register interface value and read data. It is used for status/interrupt fields, sticky flags and lockable control fields across generated register blocks.

## Interface
- `MSB`, 0, upper bit position of the field within the register.
- `LSB`, 0, lower bit position; field width W = MSB-LSB+1.
- `INITIAL_VALUE`, '0, W-bit value loaded on reset.
- `MODE`, 0, software access mode: 0 RW, 1 W1C, 2 W1S, 3 RC; any other value is a fatal elaboration error.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `register_if`  modport `rggen_register_if.data`  —  drives `value[MSB:LSB]` and `read_data[MSB:LSB]`; uses `write_access()`, `read_access()`, `write_data`, `write_mask`.
- `i_set`  input  W  per-bit hardware set.
- `i_clear`  input  W  per-bit hardware clear.
- `i_lock`  input  1  high blocks all software writes.
- `o_value`  output  W  current field value.
- `o_value_changed`  output  1  one-cycle pulse after any bit of the field changes.
- `i_hw_write_enable`  input  1  hardware whole-field load (present only with `RGGEN_BIT_FIELD_HW_WRITE_EN`).
- `i_hw_write_data`  input  W  hardware load data (present only with `RGGEN_BIT_FIELD_HW_WRITE_EN`).

## Operation
- `o_value`, `register_if.value[MSB:LSB]`, `register_if.read_data[MSB:LSB]` all equal the stored value `v` (combinational from the flop).
- Next value computed per bit, in order; later steps override earlier ones:
  1. Software step `s`, applied only when `write_access()` and `!i_lock`, with masked bits m = `write_mask`, d = `write_data`:
     - RW: s = (v & ~m) | (d & m).
     - W1C: s = v & ~(d & m).
     - W1S: s = v | (d & m).
     - RC: writes ignored, so s = v. On `read_access()`, s = '0 regardless of `i_lock`.
     - No access, or locked write: s = v.
  2. Hardware load (macro only): if `i_hw_write_enable`, h = `i_hw_write_data`, else h = s.
  3. Set: t = h | `i_set`.
  4. Clear: next = t & ~`i_clear`. Clear wins over set, load and software.
- The RC read returns the pre-clear value in the same cycle. Clearing is visible from the next cycle.
- `o_value_changed` is registered: at each edge it takes (next != v).

## Timing
- Reset (asynchronous assert, deassert sampled on `clk`): v = `INITIAL_VALUE`, `o_value_changed` = 0.
- Latency from a write, set, clear or load to `o_value` is one cycle. `o_value_changed` is high in the same cycle as the new value and lasts one cycle per change.
- Continuous changes keep `o_value_changed` high.
- Simultaneous events resolve per bit by the Operation order. A write and read in the same cycle on RC: the read clear is applied.
- Reset mid-operation discards any pending update immediately; no change pulse is produced by reset.

## Configuration
- `RGGEN_BIT_FIELD_HW_WRITE_EN` defined: `i_hw_write_enable`/`i_hw_write_data` ports exist, and step 2 is active.
- Not defined: ports absent, h = s.

## Test plan
- Reset with W=8, INITIAL_VALUE=8'hA5 -> `o_value`=8'hA5, `read_data[MSB:LSB]`=8'hA5, `o_value_changed`=0.
- MODE=RW, v=8'h00, write d=8'hFF m=8'h0F -> next cycle v=8'h0F, `o_value_changed`=1 for one cycle. Repeating the same write -> pulse stays 0.
- MODE=W1C, v=8'hF0, `i_set`=8'h10 held, write d=8'h30 m=8'hFF -> v=8'hD0 (set beats W1C on bit 4). `i_clear`=8'h10 same cycle -> v=8'hC0.
- MODE=RC, v=8'h3C, read -> `read_data`=8'h3C that cycle, v=8'h00 next. `i_lock`=1 write d=8'hFF -> v stays 8'h00.
- MODE=RW, `i_lock`=1, write d=8'h55 m=8'hFF -> v unchanged, no pulse. Lock released, same write -> v=8'h55.
- Macro on, MODE=W1S: `i_hw_write_enable`=1 data 8'h81 with software write d=8'h02 -> v=8'h81. Add `i_clear`=8'h01 -> v=8'h80.

Source files
------------

// File: rtl/rggen_bit_field_multi_mode_if.sv
// rtl/rggen_bit_field_multi_mode_if.sv - register interface shared by bit fields of one register
interface rggen_register_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  write_valid;
    logic                  read_valid;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] read_data;

    function automatic logic write_access();
        return write_valid;
    endfunction

    function automatic logic read_access();
        return read_valid;
    endfunction

    modport master (
        output write_valid, read_valid, write_data, write_mask,
        input  value, read_data,
        import write_access, read_access
    );

    modport data (
        input  write_valid, read_valid, write_data, write_mask,
        output value, read_data,
        import write_access, read_access
    );
endinterface

// File: rtl/rggen_bit_field_multi_mode.sv
// rtl/rggen_bit_field_multi_mode.sv - multi-mode bit field (RW/W1C/W1S/RC) with hw set/clear, lock, change pulse
// Optional hardware whole-field load enabled by RGGEN_BIT_FIELD_HW_WRITE_EN.
module rggen_bit_field_multi_mode #(
    parameter int                 MSB           = 0,
    parameter int                 LSB           = 0,
    parameter logic [MSB-LSB:0]   INITIAL_VALUE = '0,
    parameter int                 MODE          = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    rggen_register_if.data     register_if,
    input  logic [MSB-LSB:0]   i_set,
    input  logic [MSB-LSB:0]   i_clear,
    input  logic               i_lock,
    output logic [MSB-LSB:0]   o_value,
    output logic               o_value_changed
`ifdef RGGEN_BIT_FIELD_HW_WRITE_EN
    ,
    input  logic               i_hw_write_enable,
    input  logic [MSB-LSB:0]   i_hw_write_data
`endif
);
    localparam int MODE_RW  = 0;
    localparam int MODE_W1C = 1;
    localparam int MODE_W1S = 2;
    localparam int MODE_RC  = 3;

    generate
        if (MODE < MODE_RW || MODE > MODE_RC) begin : g_bad_mode
            $fatal(1, "rggen_bit_field_multi_mode: unsupported MODE %0d", MODE);
        end
    endgenerate

    logic [MSB-LSB:0] value_q;
    logic [MSB-LSB:0] value_d;
    logic             changed_q;
    logic [MSB-LSB:0] sw_value;
    logic [MSB-LSB:0] hw_value;
    logic [MSB-LSB:0] wdata;
    logic [MSB-LSB:0] wmask;
    logic             sw_write;
    logic             sw_read;

    assign wdata    = register_if.write_data[MSB:LSB];
    assign wmask    = register_if.write_mask[MSB:LSB];
    assign sw_write = register_if.write_access() && !i_lock;
    assign sw_read  = register_if.read_access();

    // RC ignores writes entirely; its read clear is not subject to the lock.
    always_comb begin
        sw_value = value_q;
        case (MODE)
            MODE_RW:  if (sw_write) sw_value = (value_q & ~wmask) | (wdata & wmask);
            MODE_W1C: if (sw_write) sw_value = value_q & ~(wdata & wmask);
            MODE_W1S: if (sw_write) sw_value = value_q | (wdata & wmask);
            MODE_RC:  if (sw_read)  sw_value = '0;
            default:  sw_value = value_q;
        endcase
    end

`ifdef RGGEN_BIT_FIELD_HW_WRITE_EN
    assign hw_value = i_hw_write_enable ? i_hw_write_data : sw_value;
`else
    assign hw_value = sw_value;
`endif

    // Clear is applied last so it wins over set, load and software.
    assign value_d = (hw_value | i_set) & ~i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q   <= INITIAL_VALUE;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            changed_q <= (value_d != value_q);
        end
    end

    assign o_value                        = value_q;
    assign o_value_changed                = changed_q;
    assign register_if.value[MSB:LSB]     = value_q;
    assign register_if.read_data[MSB:LSB] = value_q;
endmodule
